// File: rtl/nubus_pkg.sv
// Shared NuBus master definitions: FSM states, ACK-cycle status codes and
// the helper that turns a latched transfer mode into active-low TM drive.
package nubus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_ATTN
  } mst_state_e;

  // Status as reported by the slave on TM1/TM0 during the ACK cycle
  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_ERR     = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_RETRY   = 2'b11
  } ack_status_e;

  // Address-cycle transfer modes as carried on cpu_tm (TM1, TM0)
  localparam logic [1:0] TM_MODE_0 = 2'b00;
  localparam logic [1:0] TM_MODE_1 = 2'b01;
  localparam logic [1:0] TM_MODE_2 = 2'b10;
  localparam logic [1:0] TM_MODE_3 = 2'b11;

  function automatic logic [1:0] tm_drive(input logic [1:0] tm);
    return ~tm;
  endfunction

endpackage

// File: rtl/nubus_tmo_counter.sv
// Data-phase watchdog: counts enabled cycles since the last clear and
// pulses expire on the TMO_CYCLES-th enabled cycle.
module nubus_tmo_counter #(
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/nubus_master.sv
// NuBus bus master sequencer: arbitration, address/data cycles, locked
// sequences closed by NULL-ATTN. Optional data-phase timeout: NUBUS_MST_TIMEOUT_EN.
module nubus_master
  import nubus_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic       nub_clkn,
  input  logic       nub_resetn,
  input  logic       cpu_valid,
  input  logic       cpu_lock,
  input  logic [1:0] cpu_tm,
  output logic       cpu_ready,
  output logic       cpu_done,
  output logic [1:0] cpu_status,
  input  logic       nub_startn,
  input  logic       nub_ackn,
  input  logic       nub_rqstn,
  input  logic [1:0] nub_tmn,
  input  logic       arb_win,
  output logic       mst_arbcyn,
  output logic       mst_adrcyn,
  output logic       mst_dtacyn,
  output logic       mst_ownern,
  output logic       mst_lockedn,
  output logic       mst_tm1n,
  output logic       mst_tm0n,
  output logic       mst_timeout
);

  if (TMO_CYCLES < 1) begin : g_bad_tmo
    $error("TMO_CYCLES must be at least 1");
  end

  mst_state_e state_q, state_d;
  logic       lock_q, lock_d;
  logic [1:0] tm_q, tm_d;
  logic       win_q, win_d;
  logic       busy_q, busy_d;
  logic       inhibit_q, inhibit_d;
  logic       done_q, done_d;
  logic [1:0] status_q, status_d;
  logic       ready_c;
  logic       to_idle;
  logic       owner;
  logic       tmo_expire;

  assign owner = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_ATTN);

`ifdef NUBUS_MST_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_clr = (state_q == S_ADDR);
  assign tmo_en  = (state_q == S_DATA) && nub_ackn;

  nubus_tmo_counter #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk   (nub_clkn),
    .rst_n (nub_resetn),
    .clear (tmo_clr),
    .enable(tmo_en),
    .expire(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    tm_d        = tm_q;
    win_d       = 1'b0;
    done_d      = 1'b0;
    status_d    = status_q;
    ready_c     = 1'b0;
    to_idle     = 1'b0;
    mst_arbcyn  = 1'b1;
    mst_adrcyn  = 1'b1;
    mst_dtacyn  = 1'b1;
    mst_ownern  = 1'b1;
    mst_lockedn = 1'b1;
    mst_tm1n    = 1'b1;
    mst_tm0n    = 1'b1;

    // Foreign START marks the bus busy until its ACK; our own START is ignored
    busy_d = busy_q;
    if (!nub_startn && !owner) begin
      busy_d = 1'b1;
    end else if (!nub_ackn) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_valid && !inhibit_q) begin
          ready_c = 1'b1;
          tm_d    = cpu_tm;
          lock_d  = cpu_lock;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        mst_arbcyn = 1'b0;
        win_d      = arb_win;
        if (arb_win && win_q && !busy_d) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        mst_ownern             = 1'b0;
        mst_adrcyn             = 1'b0;
        mst_arbcyn             = 1'b0;
        mst_lockedn            = ~lock_q;
        {mst_tm1n, mst_tm0n}   = tm_drive(tm_q);
        state_d                = S_DATA;
      end
      S_DATA: begin
        mst_ownern  = 1'b0;
        mst_dtacyn  = 1'b0;
        mst_arbcyn  = ~lock_q;
        mst_lockedn = ~lock_q;
        if (!nub_ackn || tmo_expire) begin
          done_d   = 1'b1;
          status_d = !nub_ackn ? ~nub_tmn : STAT_TIMEOUT;
          if (lock_q && cpu_valid) begin
            // Locked follow-on keeps the bus: straight back to an address cycle
            ready_c = 1'b1;
            tm_d    = cpu_tm;
            lock_d  = cpu_lock;
            state_d = S_ADDR;
          end else if (lock_q) begin
            state_d = S_ATTN;
          end else begin
            state_d = S_IDLE;
            to_idle = 1'b1;
          end
        end
      end
      S_ATTN: begin
        mst_ownern = 1'b0;
        state_d    = S_IDLE;
        to_idle    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    inhibit_d = inhibit_q;
    if (to_idle && !nub_rqstn) begin
      inhibit_d = 1'b1;
    end else if (nub_rqstn) begin
      inhibit_d = 1'b0;
    end
  end

  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q   <= S_IDLE;
      lock_q    <= 1'b0;
      tm_q      <= 2'b00;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      inhibit_q <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= STAT_OK;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      tm_q      <= tm_d;
      win_q     <= win_d;
      busy_q    <= busy_d;
      inhibit_q <= inhibit_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end

  // Gate the combinational acceptance so a held request is not acknowledged under reset
  assign cpu_ready  = ready_c && nub_resetn;
  assign cpu_done   = done_q;
  assign cpu_status = status_q;
  assign mst_timeout = tmo_expire;

endmodule

// File: tb/tb_nubus_master.sv
// Self-checking bench for nubus_master: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nubus_master;

  localparam int TMO = 4;
`ifdef NUBUS_MST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_ARB = 1, M_ADDR = 2, M_DATA = 3, M_ATTN = 4;

  logic       nub_clkn = 1'b0;
  logic       nub_resetn;
  logic       cpu_valid, cpu_lock;
  logic [1:0] cpu_tm;
  logic       cpu_ready, cpu_done;
  logic [1:0] cpu_status;
  logic       nub_startn, nub_ackn, nub_rqstn;
  logic [1:0] nub_tmn;
  logic       arb_win;
  logic       mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn;
  logic       mst_tm1n, mst_tm0n, mst_timeout;

  always #5 nub_clkn = ~nub_clkn;

  nubus_master #(.TMO_CYCLES(TMO)) dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .cpu_valid  (cpu_valid),
    .cpu_lock   (cpu_lock),
    .cpu_tm     (cpu_tm),
    .cpu_ready  (cpu_ready),
    .cpu_done   (cpu_done),
    .cpu_status (cpu_status),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_rqstn  (nub_rqstn),
    .nub_tmn    (nub_tmn),
    .arb_win    (arb_win),
    .mst_arbcyn (mst_arbcyn),
    .mst_adrcyn (mst_adrcyn),
    .mst_dtacyn (mst_dtacyn),
    .mst_ownern (mst_ownern),
    .mst_lockedn(mst_lockedn),
    .mst_tm1n   (mst_tm1n),
    .mst_tm0n   (mst_tm0n),
    .mst_timeout(mst_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: where the master is in a transaction, plus bus bookkeeping
  int         m_ph;
  bit         m_win_prev, m_busy, m_inh, m_lock, m_done;
  logic [1:0] m_tm, m_status;
  int         m_waited;

  // Observed DUT events, for the hand-computed scenario expectations
  int n_ready = 0, n_done = 0, n_addr = 0, n_arb_only = 0, n_attn = 0;
  int n_locked = 0, n_tmo = 0, n_data = 0, last_addr = 0, last_tmo = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_tmo_now();
    return TMO_EN && (m_ph == M_DATA) && nub_ackn && (m_waited + 1 >= TMO);
  endfunction

  function automatic bit m_complete();
    return (m_ph == M_DATA) && (!nub_ackn || m_tmo_now());
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_win_prev = 0; m_busy = 0; m_inh = 0; m_lock = 0;
    m_done = 0; m_tm = 2'b00; m_status = 2'b00; m_waited = 0;
  endtask

  task automatic check_outputs();
    bit         own;
    bit         exp_ready;
    logic [1:0] exp_tm;
    logic [1:0] act_tm;
    own       = (m_ph == M_ADDR) || (m_ph == M_DATA) || (m_ph == M_ATTN);
    exp_ready = ((m_ph == M_IDLE) && cpu_valid && !m_inh) || (m_complete() && m_lock && cpu_valid);
    exp_tm    = (m_ph == M_ADDR) ? ~m_tm : 2'b11;
    act_tm    = {mst_tm1n, mst_tm0n};
    chk("cpu_ready", cpu_ready, exp_ready);
    chk("cpu_done", cpu_done, m_done);
    chk("cpu_status", cpu_status, m_status);
    chk("mst_ownern", mst_ownern, !own);
    chk("mst_arbcyn", mst_arbcyn, !((m_ph == M_ARB) || (m_ph == M_ADDR) || (m_ph == M_DATA && m_lock)));
    chk("mst_adrcyn", mst_adrcyn, !(m_ph == M_ADDR));
    chk("mst_dtacyn", mst_dtacyn, !(m_ph == M_DATA));
    chk("mst_lockedn", mst_lockedn, !(m_lock && (m_ph == M_ADDR || m_ph == M_DATA)));
    chk("mst_tm", act_tm, exp_tm);
    chk("mst_timeout", mst_timeout, m_tmo_now());
    if (cpu_ready) n_ready++;
    if (cpu_done) n_done++;
    if (!mst_adrcyn) begin n_addr++; last_addr = cyc; end
    if (!mst_arbcyn && mst_ownern) n_arb_only++;
    if (!mst_ownern && mst_adrcyn && mst_dtacyn) n_attn++;
    if (!mst_lockedn) n_locked++;
    if (mst_timeout) begin n_tmo++; last_tmo = cyc; end
    if (!mst_dtacyn) n_data++;
  endtask

  task automatic model_step();
    bit own, cmp, busy_nx, to_idle;
    own     = (m_ph == M_ADDR) || (m_ph == M_DATA) || (m_ph == M_ATTN);
    cmp     = m_complete();
    to_idle = 0;
    busy_nx = (!nub_startn && !own) ? 1'b1 : (!nub_ackn ? 1'b0 : m_busy);
    m_done  = cmp;
    case (m_ph)
      M_IDLE: if (cpu_valid && !m_inh) begin
        m_lock = cpu_lock; m_tm = cpu_tm; m_win_prev = 0; m_ph = M_ARB;
      end
      M_ARB: begin
        if (arb_win && m_win_prev && !busy_nx) m_ph = M_ADDR;
        m_win_prev = arb_win;
      end
      M_ADDR: begin m_ph = M_DATA; m_waited = 0; end
      M_DATA: if (cmp) begin
        m_status = !nub_ackn ? ~nub_tmn : 2'b10;
        if (m_lock && cpu_valid) begin
          m_lock = cpu_lock; m_tm = cpu_tm; m_ph = M_ADDR;
        end else if (m_lock) begin
          m_ph = M_ATTN;
        end else begin
          m_ph = M_IDLE; to_idle = 1;
        end
      end else begin
        m_waited++;
      end
      M_ATTN: begin m_ph = M_IDLE; to_idle = 1; end
      default: m_ph = M_IDLE;
    endcase
    if (to_idle && !nub_rqstn) m_inh = 1;
    else if (nub_rqstn) m_inh = 0;
    m_busy = busy_nx;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1
  task automatic step();
    #4;
    check_outputs();
    @(posedge nub_clkn);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    cpu_valid = 0; cpu_lock = 0; cpu_tm = 2'b00; nub_startn = 1; nub_ackn = 1;
    nub_rqstn = 1; nub_tmn = 2'b11; arb_win = 1;
  endtask

  task automatic chk_bus_released(input string tag);
    chk({tag, "_ownern"}, mst_ownern, 1'b1);
    chk({tag, "_arbcyn"}, mst_arbcyn, 1'b1);
    chk({tag, "_adrcyn"}, mst_adrcyn, 1'b1);
    chk({tag, "_dtacyn"}, mst_dtacyn, 1'b1);
    chk({tag, "_lockedn"}, mst_lockedn, 1'b1);
    chk({tag, "_tm"}, {2'b00, mst_tm1n, mst_tm0n}, 4'b0011);
    chk({tag, "_timeout"}, mst_timeout, 1'b0);
    chk({tag, "_done"}, cpu_done, 1'b0);
    chk({tag, "_ready"}, cpu_ready, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, b_ready, b_done, b_addr, b_arb, b_attn, b_locked, b_tmo, b_data;

    idle_inputs();
    cpu_valid  = 1;
    nub_resetn = 0;
    model_reset();
    #12;
    chk_bus_released("reset");
    chk("reset_status", cpu_status, 4'h0);
    @(posedge nub_clkn); #1;
    cpu_valid  = 0;
    nub_resetn = 1;
    repeat (2) step();

    // Foreign START during arbitration: hold off until the foreign ACK
    b_done = n_done; b_addr = n_addr;
    cpu_valid = 1; cpu_tm = 2'b10; step();
    cpu_valid = 0; nub_startn = 0; step();
    nub_startn = 1; repeat (3) step();
    chk_int("busy_no_addr", n_addr - b_addr, 0);
    nub_ackn = 0; c0 = cyc; step();
    nub_ackn = 1; step();
    chk_int("busy_addr_after_ack", last_addr, c0 + 1);
    nub_ackn = 0; nub_tmn = 2'b10; step();
    nub_ackn = 1; nub_tmn = 2'b11; step();
    chk("busy_status", cpu_status, 4'h1);
    chk_int("busy_done_count", n_done - b_done, 1);
    step();

    // Plain unlocked transfer, ACK with TM=00 on the third data cycle
    b_done = n_done; b_ready = n_ready;
    c0 = cyc; cpu_valid = 1; cpu_tm = 2'b01; step();
    cpu_valid = 0; repeat (3) step();
    chk_int("basic_addr_cycle", last_addr, c0 + 3);
    repeat (2) step();
    nub_ackn = 0; nub_tmn = 2'b11; step();
    nub_ackn = 1; step();
    step();
    chk("basic_status", cpu_status, 4'h0);
    chk_int("basic_done_count", n_done - b_done, 1);
    chk_int("basic_ready_count", n_ready - b_ready, 1);

    // Locked pair: second transfer reuses the bus, closed by one NULL-ATTN
    b_done = n_done; b_addr = n_addr; b_arb = n_arb_only; b_attn = n_attn; b_locked = n_locked;
    cpu_lock = 1; cpu_valid = 1; cpu_tm = 2'b10; step();
    cpu_valid = 0; repeat (3) step();
    cpu_valid = 1; cpu_tm = 2'b11; nub_ackn = 0; step();
    cpu_valid = 0; nub_ackn = 1; step();
    nub_ackn = 0; step();
    nub_ackn = 1; cpu_lock = 0; step();
    repeat (2) step();
    chk_int("lock_addr_count", n_addr - b_addr, 2);
    chk_int("lock_arb_count", n_arb_only - b_arb, 2);
    chk_int("lock_attn_count", n_attn - b_attn, 1);
    chk_int("lock_lockedn_cycles", n_locked - b_locked, 4);
    chk_int("lock_done_count", n_done - b_done, 2);

    // Unanswered data phase
    b_done = n_done; b_tmo = n_tmo; b_data = n_data;
    cpu_valid = 1; cpu_tm = 2'b00; step();
    cpu_valid = 0; repeat (3) step();
    repeat (10) step();
`ifdef NUBUS_MST_TIMEOUT_EN
    chk_int("tmo_pulses", n_tmo - b_tmo, 1);
    chk_int("tmo_data_cycle", last_tmo - last_addr, TMO);
    chk_int("tmo_data_cycles", n_data - b_data, TMO);
    chk("tmo_status", cpu_status, 4'h2);
    chk_int("tmo_done_count", n_done - b_done, 1);
`else
    chk_int("notmo_pulses", n_tmo - b_tmo, 0);
    chk_int("notmo_data_cycles", n_data - b_data, 10);
    chk_int("notmo_no_done", n_done - b_done, 0);
    nub_ackn = 0; nub_tmn = 2'b00; step();
    nub_ackn = 1; nub_tmn = 2'b11; step();
    chk("notmo_status", cpu_status, 4'h3);
    chk_int("notmo_done_count", n_done - b_done, 1);
`endif
    step();

    // Fairness: RQST* held low at completion blocks the next request
    cpu_valid = 1; step();
    cpu_valid = 0; repeat (3) step();
    nub_rqstn = 0; nub_ackn = 0; step();
    nub_ackn = 1; cpu_valid = 1; b_ready = n_ready;
    repeat (4) step();
    chk_int("inhibit_blocked", n_ready - b_ready, 0);
    nub_rqstn = 1; step();
    chk_int("inhibit_release_cycle", n_ready - b_ready, 0);
    step();
    chk_int("inhibit_released", n_ready - b_ready, 1);
    cpu_valid = 0; repeat (3) step();
    nub_ackn = 0; step();
    nub_ackn = 1; repeat (2) step();

    // Reset in the middle of a data phase
    b_done = n_done;
    cpu_valid = 1; step();
    cpu_valid = 0; repeat (3) step();
    chk("pre_reset_in_data", mst_dtacyn, 1'b0);
    #2 nub_resetn = 0;
    #1;
    chk_bus_released("midreset");
    model_reset();
    @(posedge nub_clkn); #1;
    nub_resetn = 1;
    repeat (3) step();
    chk_int("midreset_no_done", n_done - b_done, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cpu_valid  = ($urandom_range(0, 3) != 0);
      cpu_lock   = ($urandom_range(0, 2) == 0);
      cpu_tm     = 2'($urandom_range(0, 3));
      arb_win    = ($urandom_range(0, 3) != 0);
      nub_startn = ($urandom_range(0, 9) != 0);
      nub_ackn   = ($urandom_range(0, 2) != 0);
      nub_rqstn  = ($urandom_range(0, 3) != 0);
      nub_tmn    = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
